// File: rtl/gb80_timer_bank.sv
// rtl/gb80_timer_bank.sv - free-running DIV counter plus NUM_TIMERS TIMA/TMA/TAC timer channels on the GB80 bus
module gb80_timer_bank #(
  parameter int          NUM_TIMERS = 1,
  parameter logic [15:0] BASE_ADDR  = 16'hFF04
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [15:0]           addr_ext,
  inout  wire  [7:0]            data_ext,
  input  logic                  mem_re,
  input  logic                  mem_we,
  output logic                  reg_hit,
  output logic [NUM_TIMERS-1:0] timer_interrupt,
  output logic                  timer_irq_any
);

  localparam logic [15:0] LAST_OFF = 16'(3 * NUM_TIMERS);

  logic [15:0]           div_cnt;
  logic [7:0]            tima [NUM_TIMERS];
  logic [7:0]            tma  [NUM_TIMERS];
  logic [3:0]            tac  [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] sel_prev;
  logic [NUM_TIMERS-1:0] sel_cur;
  logic [NUM_TIMERS-1:0] tick;
  logic [NUM_TIMERS-1:0] tima_wr;
  logic [NUM_TIMERS-1:0] tma_wr;
  logic [NUM_TIMERS-1:0] tac_wr;
  logic [15:0]           offset;
  logic                  div_wr;
  logic [7:0]            rdata;
  logic [7:0]            wdata;

  // Selected DIV tap for a TAC value; the enable is folded in by the caller.
  function automatic logic tap_bit(input logic [1:0] sel, input logic [15:0] cnt);
    case (sel)
      2'b00:   tap_bit = cnt[9];
      2'b01:   tap_bit = cnt[3];
      2'b10:   tap_bit = cnt[5];
      default: tap_bit = cnt[7];
    endcase
  endfunction

  // The lower bound guards against the subtraction wrapping for addresses below the window.
  assign offset        = addr_ext - BASE_ADDR;
  assign reg_hit       = (addr_ext >= BASE_ADDR) && (offset <= LAST_OFF);
  assign wdata         = data_ext;
  assign div_wr        = mem_we & reg_hit & (offset == 16'd0);
  assign tick          = sel_prev & ~sel_cur;
  assign timer_irq_any = |timer_interrupt;
  assign data_ext      = (mem_re & reg_hit & ~mem_we) ? rdata : 8'hzz;

  // Register decode: read mux, per-channel write strobes and the tap level fed to the edge detector.
  always_comb begin
    rdata   = 8'h00;
    tima_wr = '0;
    tma_wr  = '0;
    tac_wr  = '0;
    sel_cur = '0;
    if (offset == 16'd0) rdata = div_cnt[15:8];
    for (int i = 0; i < NUM_TIMERS; i++) begin
      tima_wr[i] = mem_we & reg_hit & (offset == 16'(1 + 3 * i));
      tma_wr[i]  = mem_we & reg_hit & (offset == 16'(2 + 3 * i));
      tac_wr[i]  = mem_we & reg_hit & (offset == 16'(3 + 3 * i));
      sel_cur[i] = tac[i][2] & tap_bit(tac[i][1:0], div_cnt);
      if (offset == 16'(1 + 3 * i)) rdata = tima[i];
      if (offset == 16'(2 + 3 * i)) rdata = tma[i];
      if (offset == 16'(3 + 3 * i)) rdata = {4'h0, tac[i]};
    end
  end

  // DIV runs every clock; any write to it restarts from zero, which may itself produce a tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    div_cnt <= 16'h0000;
    else if (div_wr) div_cnt <= 16'h0000;
    else             div_cnt <= div_cnt + 16'd1;
  end

  // Channel state: a CPU write to TIMA beats a tick, and a same-cycle TMA write feeds the reload.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        tima[i] <= 8'h00;
        tma[i]  <= 8'h00;
        tac[i]  <= 4'h0;
      end
      sel_prev        <= '0;
      timer_interrupt <= '0;
    end else begin
      sel_prev        <= sel_cur;
      timer_interrupt <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (tma_wr[i]) tma[i] <= wdata;
        if (tac_wr[i]) tac[i] <= wdata[3:0];
        if (tima_wr[i]) begin
          tima[i] <= wdata;
        end else if (tick[i]) begin
          if (tima[i] == 8'hFF) begin
            timer_interrupt[i] <= 1'b1;
            if (tac[i][3]) begin
              tima[i] <= 8'h00;
              if (!tac_wr[i]) tac[i][2] <= 1'b0;
            end else begin
              tima[i] <= tma_wr[i] ? wdata : tma[i];
            end
          end else begin
            tima[i] <= tima[i] + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gb80_timer_bank.sv
// tb/tb_gb80_timer_bank.sv - scoreboard bench for gb80_timer_bank with three channels
module tb_gb80_timer_bank;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addr_ext = 16'h0000;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic        tb_drv = 1'b0;
  logic [7:0]  tb_dout = 8'h00;
  wire  [7:0]  data_ext;
  logic        reg_hit;
  logic [2:0]  timer_interrupt;
  logic        timer_irq_any;

  assign data_ext = tb_drv ? tb_dout : 8'hzz;

  gb80_timer_bank #(.NUM_TIMERS(3), .BASE_ADDR(16'hFF04)) dut (
    .clock(clock), .reset_n(reset_n), .addr_ext(addr_ext), .data_ext(data_ext),
    .mem_re(mem_re), .mem_we(mem_we), .reg_hit(reg_hit),
    .timer_interrupt(timer_interrupt), .timer_irq_any(timer_irq_any)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int cyc; logic [7:0] data; logic hit; } rd_exp_t;
  typedef struct { int cyc; logic [2:0] mask; } irq_exp_t;
  rd_exp_t  rd_q[$];
  string    rd_name_q[$];
  irq_exp_t irq_q[$];
  rd_exp_t  re;
  irq_exp_t ie;
  string    nm;

  // Read monitor: every cycle with mem_re asserted consumes one expected read.
  always @(negedge clock) begin
    if (mem_re) begin
      n_tests++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read cyc=%0d addr=%h", cyc, addr_ext);
      end else begin
        re = rd_q.pop_front();
        nm = rd_name_q.pop_front();
        if (reg_hit !== re.hit || (re.hit && data_ext !== re.data) || cyc != re.cyc) begin
          n_fail++;
          $display("FAIL %s: got hit=%b data=%h cyc=%0d, expected hit=%b data=%h cyc=%0d",
                   nm, reg_hit, data_ext, cyc, re.hit, re.data, re.cyc);
        end
      end
    end
  end

  // Interrupt monitor: every pulse cycle consumes one expected pulse.
  always @(negedge clock) begin
    if (timer_interrupt != 3'b000 || timer_irq_any) begin
      n_tests++;
      if (irq_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_irq cyc=%0d irq=%b any=%b", cyc, timer_interrupt, timer_irq_any);
      end else begin
        ie = irq_q.pop_front();
        if (timer_interrupt !== ie.mask || timer_irq_any !== 1'b1 || cyc != ie.cyc) begin
          n_fail++;
          $display("FAIL irq: got irq=%b any=%b cyc=%0d, expected irq=%b any=1 cyc=%0d",
                   timer_interrupt, timer_irq_any, cyc, ie.mask, ie.cyc);
        end
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d, output int edge_idx);
    addr_ext = a; tb_dout = d; tb_drv = 1'b1; mem_we = 1'b1;
    @(posedge clock); #1;
    mem_we = 1'b0; tb_drv = 1'b0;
    edge_idx = cyc;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] d, input logic h, input string name);
    addr_ext = a; mem_re = 1'b1;
    rd_q.push_back('{cyc, d, h});
    rd_name_q.push_back(name);
    @(posedge clock); #1;
    mem_re = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    if (cyc > t) begin
      n_fail++;
      $display("FAIL schedule: now cyc=%0d, required at most %0d", cyc, t);
    end
    while (cyc < t) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic push_irq(input int c, input logic [2:0] m);
    irq_q.push_back('{c, m});
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  int e, d0, d2, d3, d4, eg;

  initial begin
    repeat (3) begin @(posedge clock); #1; end
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Mid-count reset.
    wr(16'hFF05, 8'h10, e);
    wr(16'hFF07, 8'h05, e);
    repeat (40) begin @(posedge clock); #1; end
    #3 reset_n = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    rd(16'hFF04, 8'h00, 1'b1, "rst_div");
    rd(16'hFF05, 8'h00, 1'b1, "rst_tima0");
    rd(16'hFF06, 8'h00, 1'b1, "rst_tma0");
    rd(16'hFF07, 8'h00, 1'b1, "rst_tac0");
    rd(16'hFF0D, 8'h00, 1'b1, "hit_ff0d");
    rd(16'hFF0E, 8'h00, 1'b0, "miss_ff0e");
    rd(16'hFF03, 8'h00, 1'b0, "miss_ff03");

    // Reload mode, TMA=FE, /16.
    wr(16'hFF04, 8'h00, d0);
    wr(16'hFF06, 8'hFE, e);
    wr(16'hFF05, 8'hFE, e);
    wr(16'hFF07, 8'h05, e);
    push_irq(d0 + 33, 3'b001);
    push_irq(d0 + 65, 3'b001);
    push_irq(d0 + 97, 3'b001);
    push_irq(d0 + 145, 3'b001);
    wait_cyc(d0 + 16);
    rd(16'hFF05, 8'hFE, 1'b1, "reload_pre_tick");
    rd(16'hFF05, 8'hFF, 1'b1, "reload_first_tick");
    wait_cyc(d0 + 32);
    rd(16'hFF05, 8'hFF, 1'b1, "reload_pre_ovf");
    rd(16'hFF05, 8'hFE, 1'b1, "reload_after_ovf");
    wait_cyc(d0 + 65);
    rd(16'hFF05, 8'hFE, 1'b1, "reload_second_ovf");

    // TIMA write on the overflow cycle wins and suppresses the interrupt.
    wait_cyc(d0 + 128);
    wr(16'hFF05, 8'h42, e);
    rd(16'hFF05, 8'h42, 1'b1, "tima_wr_beats_ovf");
    rd(16'hFF05, 8'h42, 1'b1, "tima_wr_hold");
    wr(16'hFF05, 8'hFF, e);
    // TMA write on the overflow cycle feeds the reload.
    wait_cyc(d0 + 144);
    wr(16'hFF06, 8'h80, e);
    rd(16'hFF05, 8'h80, 1'b1, "tma_wr_on_ovf");
    rd(16'hFF06, 8'h80, 1'b1, "tma_readback");

    // DIV write while the tap is high adds one extra count.
    wr(16'hFF04, 8'h00, d2);
    wr(16'hFF05, 8'h10, e);
    wait_cyc(d2 + 10);
    wr(16'hFF04, 8'h5A, d3);
    rd(16'hFF05, 8'h10, 1'b1, "div_glitch_cycle");
    rd(16'hFF05, 8'h11, 1'b1, "div_glitch_extra");
    wait_cyc(d3 + 16);
    rd(16'hFF05, 8'h11, 1'b1, "div_glitch_pre_tick");
    rd(16'hFF05, 8'h12, 1'b1, "div_glitch_next_tick");

    // One-shot mode.
    wr(16'hFF04, 8'h00, d4);
    wr(16'hFF05, 8'hFF, e);
    wr(16'hFF07, 8'h0D, e);
    push_irq(d4 + 17, 3'b001);
    wait_cyc(d4 + 18);
    rd(16'hFF07, 8'h09, 1'b1, "oneshot_tac");
    rd(16'hFF05, 8'h00, 1'b1, "oneshot_tima");
    wait_cyc(d4 + 2019);
    rd(16'hFF05, 8'h00, 1'b1, "oneshot_stopped");

    // Three independent channels at /16, /64 and /256.
    wr(16'hFF05, 8'hFF, e);
    wr(16'hFF08, 8'hFF, e);
    wr(16'hFF0B, 8'hFF, e);
    wr(16'hFF04, 8'h00, eg);
    wr(16'hFF07, 8'h05, e);
    wr(16'hFF0A, 8'h06, e);
    wr(16'hFF0D, 8'h07, e);
    push_irq(eg + 17, 3'b001);
    push_irq(eg + 65, 3'b010);
    push_irq(eg + 257, 3'b100);
    wait_cyc(eg + 18);
    rd(16'hFF05, 8'h80, 1'b1, "multi_ch0_reload");
    wait_cyc(eg + 64);
    rd(16'hFF08, 8'hFF, 1'b1, "multi_ch1_pre");
    rd(16'hFF08, 8'h00, 1'b1, "multi_ch1_ovf");
    wait_cyc(eg + 257);
    rd(16'hFF0B, 8'h00, 1'b1, "multi_ch2_ovf");
    rd(16'hFF0A, 8'h06, 1'b1, "multi_tac1");
    repeat (4) begin @(posedge clock); #1; end

    while (irq_q.size() > 0) begin
      ie = irq_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_irq: got none, expected irq=%b at cyc=%0d", ie.mask, ie.cyc);
    end
    while (rd_q.size() > 0) begin
      re = rd_q.pop_front();
      nm = rd_name_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no read, expected data=%h at cyc=%0d", nm, re.data, re.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
